matrix_sr_rx: RTL and testbench

// - Receiver end of the 8x8 RGB matrix 74HC595 chain: oversamples the shift clock (sck), latch (lat) and serial data (sdi) lines with clk.
// - Rebuilds each 32-bit row word: 8 red, 8 blue, 8 green (active-low), then 8 row-anode bits (one-hot).
// - Decodes each latched word into an 8x8 RGB frame buffer. Flags malformed transfers.
// - Used as a loopback checker / sniffer on spare gp pins and as the bench model of the matrix.

---
 rtl/matrix_sr_rx.sv | 120 ++++++++++++
 tb/tb_matrix_sr_rx.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/matrix_sr_rx.sv
// Receiver for the 8x8 RGB matrix 74HC595 chain: oversamples sck/lat/sdi, rebuilds
// 32-bit row words, classifies each latch and keeps an 8x24 frame buffer.
module matrix_sr_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sck,
  input  logic             lat,
  input  logic             sdi,
  output logic             row_valid,
  output logic [2:0]       row_idx,
  output logic [7:0]       row_red,
  output logic [7:0]       row_blue,
  output logic [7:0]       row_green,
  output logic             blank_row,
  output logic             frame_done,
  output logic             len_err,
  output logic             hot_err,
  output logic [ERR_W-1:0] err_count,
  input  logic [2:0]       rd_addr,
  output logic [23:0]      rd_data
);

  logic [SYNC_STAGES-1:0] sck_sync, lat_sync, sdi_sync;
  logic                   sck_hist, lat_hist;
  logic                   sck_s, lat_s, sdi_s, sck_rise, lat_rise;
  logic [31:0]            sr, sr_nx;
  logic [5:0]             bit_cnt, cnt_nx;
  logic [7:0]             anode, red_nx, blue_nx, green_nx;
  logic [2:0]             idx_nx;
  logic                   anode_onehot, good, blank, len_bad, hot_bad;
  logic [23:0]            fbuf [8];

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign lat_s    = lat_sync[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_hist;
  assign lat_rise = lat_s & ~lat_hist;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync <= '0;
      lat_sync <= '0;
      sdi_sync <= '0;
      sck_hist <= 1'b0;
      lat_hist <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
      lat_sync <= {lat_sync[SYNC_STAGES-2:0], lat};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      sck_hist <= sck_s;
      lat_hist <= lat_s;
    end
  end

  // A latch arriving with the final shift classifies the post-shift word.
  always_comb begin
    sr_nx  = sr;
    cnt_nx = bit_cnt;
    if (sck_rise) begin
      sr_nx = {sr[30:0], sdi_s};
      if (bit_cnt != 6'd63) cnt_nx = bit_cnt + 6'd1;
    end
    idx_nx = 3'd0;
    for (int c = 0; c < 8; c++) begin
      red_nx[c]   = ~sr_nx[31-c];
      blue_nx[c]  = ~sr_nx[23-c];
      green_nx[c] = ~sr_nx[15-c];
      anode[c]    = sr_nx[7-c];
    end
    for (int c = 0; c < 8; c++) begin
      if (anode[c]) idx_nx = 3'(c);
    end
    anode_onehot = (anode != 8'd0) && ((anode & (anode - 8'd1)) == 8'd0);
    len_bad = lat_rise && (cnt_nx != 6'd32);
    blank   = lat_rise && (cnt_nx == 6'd32) && (anode == 8'd0);
    good    = lat_rise && (cnt_nx == 6'd32) && anode_onehot;
    hot_bad = lat_rise && (cnt_nx == 6'd32) && (anode != 8'd0) && !anode_onehot;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr         <= '0;
      bit_cnt    <= '0;
      row_valid  <= 1'b0;
      row_idx    <= '0;
      row_red    <= '0;
      row_blue   <= '0;
      row_green  <= '0;
      blank_row  <= 1'b0;
      frame_done <= 1'b0;
      len_err    <= 1'b0;
      hot_err    <= 1'b0;
      err_count  <= '0;
      rd_data    <= '0;
      for (int r = 0; r < 8; r++) fbuf[r] <= '0;
    end else begin
      sr         <= sr_nx;
      bit_cnt    <= lat_rise ? 6'd0 : cnt_nx;
      row_valid  <= good;
      blank_row  <= blank;
      frame_done <= good && (idx_nx == 3'd7);
      len_err    <= len_bad;
      hot_err    <= hot_bad;
      if (good) begin
        row_idx      <= idx_nx;
        row_red      <= red_nx;
        row_blue     <= blue_nx;
        row_green    <= green_nx;
        fbuf[idx_nx] <= {red_nx, blue_nx, green_nx};
      end
      if ((len_bad || hot_bad) && (err_count != {ERR_W{1'b1}}))
        err_count <= err_count + ERR_W'(1);
      rd_data <= fbuf[rd_addr];
    end
  end

endmodule

// File: tb/tb_matrix_sr_rx.sv
// Directed bench for matrix_sr_rx: a driver serialises row words onto the pins and
// queues the expected events; a monitor pops and compares every pulse the DUT emits.
module tb_matrix_sr_rx;

  localparam int KIND_ROW = 0, KIND_BLANK = 1, KIND_LEN = 2, KIND_HOT = 3;

  typedef struct {
    int         kind;
    logic [2:0] idx;
    logic [7:0] r, b, g;
  } ev_t;

  logic        clk = 1'b0, reset = 1'b1, sck = 1'b0, lat = 1'b0, sdi = 1'b0;
  logic        row_valid, blank_row, frame_done, len_err, hot_err;
  logic [2:0]  row_idx, rd_addr = 3'd0;
  logic [7:0]  row_red, row_blue, row_green, err_count;
  logic [23:0] rd_data;

  ev_t exp_q[$];
  int  n_chk = 0, n_fail = 0, exp_err = 0;

  logic [23:0] rows_tbl [8] = '{24'h123456, 24'hFF0081, 24'h0FF03C, 24'h5AA5C3,
                                24'h80017E, 24'hE71899, 24'h00FF24, 24'hC003DB};

  matrix_sr_rx #(.SYNC_STAGES(2), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .sck(sck), .lat(lat), .sdi(sdi),
    .row_valid(row_valid), .row_idx(row_idx), .row_red(row_red), .row_blue(row_blue),
    .row_green(row_green), .blank_row(blank_row), .frame_done(frame_done),
    .len_err(len_err), .hot_err(hot_err), .err_count(err_count),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // First bit on the wire ends up in sr[31]; red column 0 is sent first, inverted.
  function automatic logic [31:0] make_word(input logic [7:0] r, b, g, a);
    logic [31:0] w;
    for (int c = 0; c < 8; c++) begin
      w[31-c] = ~r[c];
      w[23-c] = ~b[c];
      w[15-c] = ~g[c];
      w[7-c]  = a[c];
    end
    return w;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sdi = b; sck = 1'b0; tick(2);
    sck = 1'b1; tick(2);
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[31-i]);
  endtask

  task automatic pulse_lat();
    sck = 1'b0; lat = 1'b1; tick(2);
    lat = 1'b0; tick(2);
  endtask

  task automatic push(input int kind, input logic [2:0] idx, input logic [7:0] r, b, g);
    ev_t e;
    e.kind = kind; e.idx = idx; e.r = r; e.b = b; e.g = g;
    exp_q.push_back(e);
    if (kind == KIND_LEN || kind == KIND_HOT) exp_err = (exp_err == 255) ? 255 : exp_err + 1;
  endtask

  task automatic send_row(input logic [2:0] idx, input logic [7:0] r, b, g);
    push(KIND_ROW, idx, r, b, g);
    send_bits(make_word(r, b, g, 8'h01 << idx), 32);
    pulse_lat();
  endtask

  initial begin : monitor
    ev_t e;
    logic [3:0] flags;
    forever begin
      @(negedge clk);
      flags = {hot_err, len_err, blank_row, row_valid};
      if (flags != 4'd0) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_event: flags=%b with empty queue at %0t", flags, $time);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", 32'(flags), 32'(4'b0001 << e.kind));
          check("frame_done", 32'(frame_done), 32'(e.kind == KIND_ROW && e.idx == 3'd7));
          if (e.kind == KIND_ROW) begin
            check("row_idx", 32'(row_idx), 32'(e.idx));
            check("row_red", 32'(row_red), 32'(e.r));
            check("row_blue", 32'(row_blue), 32'(e.b));
            check("row_green", 32'(row_green), 32'(e.g));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    tick(3);
    check("reset_row_valid", 32'(row_valid), 0);
    check("reset_err_count", 32'(err_count), 0);
    check("reset_rd_data", 32'(rd_data), 0);
    reset = 1'b0;
    tick(3);

    // Row 3 example, then read it back from the frame buffer.
    send_row(3'd3, 8'h55, 8'h00, 8'hF0);
    tick(2);
    rd_addr = 3'd3; tick(2);
    check("rd_row3", 32'(rd_data), 32'h5500F0);

    // Full frame at the 4-clk serial period.
    for (int r = 0; r < 8; r++)
      send_row(3'(r), rows_tbl[r][23:16], rows_tbl[r][15:8], rows_tbl[r][7:0]);
    tick(6);
    check("frame_err_count", 32'(err_count), 0);
    rd_addr = 3'd4; tick(2);
    check("rd_row4", 32'(rd_data), 32'h80017E);

    // Short word: length error, frame buffer untouched, then a good word.
    push(KIND_LEN, 3'd0, 8'd0, 8'd0, 8'd0);
    send_bits(make_word(8'hAA, 8'hBB, 8'hCC, 8'h02), 31);
    pulse_lat();
    tick(6);
    check("len_err_count", 32'(err_count), 32'(exp_err));
    rd_addr = 3'd3; tick(2);
    check("rd_row3_kept", 32'(rd_data), 32'h5AA5C3);
    send_row(3'd5, 8'h3C, 8'hC3, 8'h81);

    // All ones -> anode 0xFF not one-hot; then a blank word.
    push(KIND_HOT, 3'd0, 8'd0, 8'd0, 8'd0);
    send_bits(32'hFFFFFFFF, 32);
    pulse_lat();
    push(KIND_BLANK, 3'd0, 8'd0, 8'd0, 8'd0);
    send_bits(make_word(8'h3C, 8'h3C, 8'h3C, 8'h00), 32);
    pulse_lat();
    tick(6);
    check("hot_err_count", 32'(err_count), 32'(exp_err));

    // Reset in the middle of a word.
    send_bits(make_word(8'h12, 8'h34, 8'h56, 8'h04), 17);
    sck = 1'b0;
    reset = 1'b1; tick(1);
    check("mid_reset_row_red", 32'(row_red), 0);
    check("mid_reset_row_idx", 32'(row_idx), 0);
    check("mid_reset_err_count", 32'(err_count), 0);
    check("mid_reset_rd_data", 32'(rd_data), 0);
    exp_err = 0;
    tick(2);
    reset = 1'b0; tick(3);
    check("post_reset_rd_row3", 32'(rd_data), 0);
    send_row(3'd2, 8'h12, 8'h34, 8'h56);
    tick(6);
    rd_addr = 3'd2; tick(2);
    check("rd_row2_after_reset", 32'(rd_data), 32'h123456);

    // sck and lat rise together on the 32nd bit.
    begin
      logic [31:0] w;
      w = make_word(8'hA5, 8'h5A, 8'h0F, 8'h40);
      push(KIND_ROW, 3'd6, 8'hA5, 8'h5A, 8'h0F);
      send_bits(w, 31);
      sdi = w[0]; sck = 1'b0; tick(2);
      sck = 1'b1; lat = 1'b1; tick(2);
      sck = 1'b0; lat = 1'b0; tick(2);
    end
    tick(6);

    // Error counter saturation.
    for (int i = 0; i < 260; i++) begin
      push(KIND_LEN, 3'd0, 8'd0, 8'd0, 8'd0);
      pulse_lat();
    end
    tick(6);
    check("err_count_saturated", 32'(err_count), 32'(exp_err));
    check("err_count_all_ones", 32'(err_count), 32'd255);
    push(KIND_LEN, 3'd0, 8'd0, 8'd0, 8'd0);
    pulse_lat();
    tick(6);
    check("err_count_holds", 32'(err_count), 32'd255);

    tick(10);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
